pc_sequencer: RTL and testbench

//  Multi-cycle controller for the PC-update path of the non-pipelined RISC-V core.

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/pc_next_calc.sv | 36 +++
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding and trap causes.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned TMO_W   = 8;
  localparam int unsigned RET_W   = 32;

  localparam logic [CAUSE_W-1:0] TRAP_NONE     = 2'd0;
  localparam logic [CAUSE_W-1:0] TRAP_MISALIGN = 2'd1;
  localparam logic [CAUSE_W-1:0] TRAP_TIMEOUT  = 2'd2;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection (jalr > jump > taken branch > sequential) and target alignment check.
module pc_next_calc #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_i,
  input  logic            zero_i,
  input  logic            jump_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] jalr_base_i,
  output logic [XLEN-1:0] next_pc_c,
  output logic            misalign_c
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] seq_target;

  assign jalr_sum   = jalr_base_i + imm_i;
  assign rel_target = pc_i + (imm_i << 1);
  assign seq_target = pc_i + XLEN'(4);

  always_comb begin
    next_pc_c = seq_target;
    if (jalr_i) begin
      next_pc_c = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (jump_i || (branch_i && zero_i)) begin
      next_pc_c = rel_target;
    end
  end

  // Instructions are 4-byte aligned; any low bit set in the target is a fault.
  assign misalign_c = |next_pc_c[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: fetch handshake with timeout, execute wait, PC update with traps.
module pc_sequencer #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(64'h100),
  parameter int unsigned     FETCH_TMO   = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            exec_start,
  input  logic            exec_done,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [31:0]     retired
);

  import pc_seq_pkg::*;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TMO - 1);
  localparam logic [RET_W-1:0] RET_MAX  = '1;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    next_pc_q, next_pc_d;
  logic               misalign_q, misalign_d;
  logic               halt_q, halt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               imem_req_q, imem_req_d;
  logic               exec_start_q, exec_start_d;
  logic               trap_q, trap_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  logic [XLEN-1:0]    calc_pc_c;
  logic               calc_misalign_c;

  pc_next_calc #(
    .XLEN (XLEN)
  ) u_next (
    .pc_i        (pc_q),
    .branch_i    (branch),
    .zero_i      (zero),
    .jump_i      (jump),
    .jalr_i      (jalr),
    .imm_i       (imm),
    .jalr_base_i (jalr_base),
    .next_pc_c   (calc_pc_c),
    .misalign_c  (calc_misalign_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      next_pc_q    <= RESET_PC;
      misalign_q   <= 1'b0;
      halt_q       <= 1'b0;
      tmo_q        <= '0;
      retired_q    <= '0;
      imem_req_q   <= 1'b0;
      exec_start_q <= 1'b0;
      trap_q       <= 1'b0;
      cause_q      <= TRAP_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      next_pc_q    <= next_pc_d;
      misalign_q   <= misalign_d;
      halt_q       <= halt_d;
      tmo_q        <= tmo_d;
      retired_q    <= retired_d;
      imem_req_q   <= imem_req_d;
      exec_start_q <= exec_start_d;
      trap_q       <= trap_d;
      cause_q      <= cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    next_pc_d    = next_pc_q;
    misalign_d   = misalign_q;
    halt_d       = halt_q;
    tmo_d        = tmo_q;
    retired_d    = retired_q;
    exec_start_d = 1'b0;
    trap_d       = 1'b0;
    cause_d      = cause_q;

    unique case (state_q)
      ST_FETCH: begin
        // The first cycle after reset has no request on the bus yet, so nothing is accepted.
        if (imem_req_q) begin
          if (imem_ack) begin
            state_d      = ST_EXEC;
            exec_start_d = 1'b1;
            tmo_d        = '0;
          end else if (tmo_q == TMO_LAST) begin
            trap_d  = 1'b1;
            cause_d = TRAP_TIMEOUT;
            pc_d    = TRAP_VECTOR;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          next_pc_d  = calc_pc_c;
          misalign_d = calc_misalign_c;
          halt_d     = halt;
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        retired_d = (retired_q == RET_MAX) ? retired_q : retired_q + RET_W'(1);
        if (misalign_q) begin
          pc_d    = TRAP_VECTOR;
          trap_d  = 1'b1;
          cause_d = TRAP_MISALIGN;
        end else begin
          pc_d = next_pc_q;
        end
        state_d = halt_q ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Request is registered and tracks the state being entered.
  assign imem_req_d = (state_d == ST_FETCH);

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign exec_start = exec_start_q;
  assign pc         = pc_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer plus hand sequences for timeout, halt and reset.
module tb_pc_sequencer;

  localparam int unsigned XLEN = 64;

  logic            clk;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic            exec_start;
  logic            exec_done;
  logic            branch;
  logic            zero;
  logic            jump;
  logic            jalr;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] jalr_base;
  logic            halt;
  logic [XLEN-1:0] pc;
  logic            trap;
  logic [1:0]      trap_cause;
  logic [31:0]     retired;

  int total;
  int bad;

  pc_sequencer #(
    .XLEN        (64),
    .RESET_PC    (64'h0),
    .TRAP_VECTOR (64'h100),
    .FETCH_TMO   (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .branch     (branch),
    .zero       (zero),
    .jump       (jump),
    .jalr       (jalr),
    .imm        (imm),
    .jalr_base  (jalr_base),
    .halt       (halt),
    .pc         (pc),
    .trap       (trap),
    .trap_cause (trap_cause),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        zr;
    logic        jp;
    logic        jr;
    logic [63:0] imm_v;
    logic [63:0] base_v;
    logic [63:0] exp_pc;
    logic        exp_trap;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check("imem_req_wait", 64'(imem_req), 64'd1);
  endtask

  task automatic clear_ctrl();
    exec_done = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
    jump      = 1'b0;
    jalr      = 1'b0;
    imm       = '0;
    jalr_base = '0;
    halt      = 1'b0;
  endtask

  task automatic run_instr(input logic br, input logic zr, input logic jp, input logic jr,
                           input logic [63:0] imm_v, input logic [63:0] base_v, input logic hlt,
                           input logic [63:0] exp_addr, input logic [63:0] exp_pc,
                           input logic exp_trap, input logic [1:0] exp_cause,
                           input logic [31:0] exp_ret);
    wait_req();
    check("imem_addr", imem_addr, exp_addr);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("exec_start_pulse", 64'(exec_start), 64'd1);
    check("req_low_in_exec", 64'(imem_req), 64'd0);
    branch    = br;
    zero      = zr;
    jump      = jp;
    jalr      = jr;
    imm       = imm_v;
    jalr_base = base_v;
    halt      = hlt;
    exec_done = 1'b1;
    step();
    clear_ctrl();
    check("exec_start_once", 64'(exec_start), 64'd0);
    step();
    check("pc_update", pc, exp_pc);
    check("trap", 64'(trap), 64'(exp_trap));
    check("trap_cause", 64'(trap_cause), 64'(exp_cause));
    check("retired", 64'(retired), 64'(exp_ret));
    check("req_after_update", 64'(imem_req), 64'(!hlt));
  endtask

  initial begin
    logic [63:0] prev_pc;
    total = 0;
    bad   = 0;

    //          br    zr    jp    jr    imm                     base                    exp_pc     trap  cause
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                  64'h0,                  64'h4,     1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                  64'h0,                  64'h8,     1'b0, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                  64'h0,                  64'hC,     1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'hA,                  64'h0,                  64'h20,    1'b0, 2'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h8,                  64'h0,                  64'h30,    1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                  64'h20,    1'b0, 2'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h8,                  64'h0,                  64'h24,    1'b0, 2'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h3,                  64'h1001,               64'h1004,  1'b0, 2'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h2,                  64'h3E,                 64'h40,    1'b0, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h1,                  64'h0,                  64'h100,   1'b1, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                  64'h0,                  64'h104,   1'b0, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h0,                  64'h200,                64'h200,   1'b0, 2'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0,                  64'h203,                64'h100,   1'b1, 2'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h8,                  64'hFFFF_FFFF_FFFF_FFFC, 64'h4,     1'b0, 2'd1};

    rst      = 1'b1;
    imem_ack = 1'b0;
    clear_ctrl();
    step();
    step();
    rst = 1'b0;
    check("rst_pc", pc, 64'h0);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_exec_start", 64'(exec_start), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_cause", 64'(trap_cause), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    step();
    check("req_rises", 64'(imem_req), 64'd1);

    prev_pc = 64'h0;
    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i].br, vecs[i].zr, vecs[i].jp, vecs[i].jr, vecs[i].imm_v, vecs[i].base_v,
                1'b0, prev_pc, vecs[i].exp_pc, vecs[i].exp_trap, vecs[i].exp_cause, 32'(i + 1));
      prev_pc = vecs[i].exp_pc;
    end

    // Fetch timeout; exec_done during FETCH must be ignored.
    for (int i = 1; i <= 14; i++) begin
      exec_done = (i <= 3);
      jump      = (i <= 3);
      imm       = 64'h40;
      step();
      check("tmo_no_trap", 64'(trap), 64'd0);
      check("tmo_pc_hold", pc, 64'h4);
    end
    clear_ctrl();
    step();
    check("tmo_trap", 64'(trap), 64'd1);
    check("tmo_cause", 64'(trap_cause), 64'd2);
    check("tmo_pc", pc, 64'h100);
    check("tmo_req", 64'(imem_req), 64'd1);
    step();
    check("tmo_pulse_end", 64'(trap), 64'd0);
    check("tmo_cause_held", 64'(trap_cause), 64'd2);

    // Slow execute; imem_ack during EXEC is ignored.
    imem_ack = 1'b1;
    step();
    check("slow_exec_start", 64'(exec_start), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("slow_exec_start_low", 64'(exec_start), 64'd0);
      check("slow_req_low", 64'(imem_req), 64'd0);
      check("slow_pc_hold", pc, 64'h100);
    end
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    step();
    clear_ctrl();
    step();
    check("slow_pc", pc, 64'h104);
    check("slow_retired", 64'(retired), 64'd15);
    check("slow_trap", 64'(trap), 64'd0);

    // Halt after the current instruction.
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h104, 64'h108, 1'b0, 2'd2, 32'd16);
    imem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("halt_req", 64'(imem_req), 64'd0);
      check("halt_pc", pc, 64'h108);
      check("halt_exec_start", 64'(exec_start), 64'd0);
    end
    imem_ack = 1'b0;

    // Reset out of HALTED, then partial wait clears on ack, then reset mid-FETCH.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_pc", pc, 64'h0);
    check("rst2_retired", 64'(retired), 64'd0);
    check("rst2_cause", 64'(trap_cause), 64'd0);
    check("rst2_req", 64'(imem_req), 64'd0);
    step();
    check("rst2_req_rise", 64'(imem_req), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("wait10_no_trap", 64'(trap), 64'd0);
    end
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 64'h4, 1'b0, 2'd0, 32'd1);
    for (int i = 0; i < 14; i++) begin
      step();
      check("tmo_cleared_no_trap", 64'(trap), 64'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst3_req", 64'(imem_req), 64'd0);
    check("rst3_pc", pc, 64'h0);
    check("rst3_retired", 64'(retired), 64'd0);
    step();
    check("rst3_req_rise", 64'(imem_req), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
